// File: rtl/uart_receiver_if.sv
// Received-byte port: valid/ready handshake carrying one byte per transfer.
// The receiver drives through the master modport; the consumer uses slave.
interface uart_receiver_if;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady;

  modport master (output DataOut, output DataOutValid, input DataOutReady);
  modport slave  (input DataOut, input DataOutValid, output DataOutReady);
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, idle-high line. Bytes are handed to the
// consumer through a one-entry holding register with valid/ready semantics.
module uart_receiver #(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  SIn,
  uart_receiver_if.master       rxData,
  output logic                  FramingError,
  output logic                  Overrun,
  output logic                  Busy
);

  localparam int SymbolEdgeTime = ClockFreq / BaudRate;
  localparam int SampleTime     = SymbolEdgeTime / 2;
  localparam int CntW           = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;

  localparam logic [CntW-1:0] CntOne     = CntW'(1);
  localparam logic [CntW-1:0] SampleLast = CntW'(SampleTime - 1);
  localparam logic [CntW-1:0] SymbolLast = CntW'(SymbolEdgeTime - 1);

  typedef enum logic [2:0] {
    Idle,
    Start,
    Data,
    Stop,
    WaitHigh
  } state_t;

  state_t          state, stateNext;
  logic            sync1, rx;
  logic [CntW-1:0] cycleCnt, cntNext;
  logic [2:0]      bitCnt, bitNext;
  logic [7:0]      shiftReg, shiftNext;
  logic            byteDone, doneNext;
  logic            stopErr, errNext;

  logic [7:0]      dataOutReg;
  logic            validReg;
  logic            feReg;
  logic            ovReg;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1    <= 1'b1;
      rx       <= 1'b1;
      state    <= Idle;
      cycleCnt <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      byteDone <= 1'b0;
      stopErr  <= 1'b0;
    end else begin
      sync1    <= SIn;
      rx       <= sync1;
      state    <= stateNext;
      cycleCnt <= cntNext;
      bitCnt   <= bitNext;
      shiftReg <= shiftNext;
      byteDone <= doneNext;
      stopErr  <= errNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cycleCnt + CntOne;
    bitNext   = bitCnt;
    shiftNext = shiftReg;
    doneNext  = 1'b0;
    errNext   = 1'b0;
    unique case (state)
      Idle: begin
        cntNext = '0;
        bitNext = '0;
        if (!rx) stateNext = Start;
      end
      Start: begin
        if (cycleCnt == SampleLast) begin
          cntNext   = '0;
          stateNext = rx ? Idle : Data;
        end
      end
      Data: begin
        // Shifting in from the top leaves the first (LSB) bit at bit 0 after eight samples.
        if (cycleCnt == SymbolLast) begin
          cntNext   = '0;
          shiftNext = {rx, shiftReg[7:1]};
          bitNext   = bitCnt + 3'd1;
          if (bitCnt == 3'd7) stateNext = Stop;
        end
      end
      Stop: begin
        if (cycleCnt == SymbolLast) begin
          cntNext = '0;
          if (rx) begin
            stateNext = Idle;
            doneNext  = 1'b1;
          end else begin
            stateNext = WaitHigh;
            errNext   = 1'b1;
          end
        end
      end
      WaitHigh: begin
        cntNext = '0;
        if (rx) stateNext = Idle;
      end
      default: stateNext = Idle;
    endcase
  end

  // Completion is resolved one cycle after the stop sample, so a handshake in
  // that same cycle frees the holding register for the new byte.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      dataOutReg <= '0;
      validReg   <= 1'b0;
      feReg      <= 1'b0;
      ovReg      <= 1'b0;
    end else begin
      feReg <= stopErr;
      ovReg <= 1'b0;
      if (byteDone) begin
        if (!validReg || rxData.DataOutReady) begin
          dataOutReg <= shiftReg;
          validReg   <= 1'b1;
        end else begin
          ovReg <= 1'b1;
        end
      end else if (validReg && rxData.DataOutReady) begin
        validReg <= 1'b0;
      end
    end
  end

  assign rxData.DataOut      = dataOutReg;
  assign rxData.DataOutValid = validReg;
  assign FramingError        = feReg;
  assign Overrun             = ovReg;
  assign Busy                = (state != Idle);

endmodule
